// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// Contents:
//   state_t   - controller state encoding (IDLE, SHIFT, DONE)
//   CNT_W_MIN - smallest bit counter width allowed
//   cnt_width - bit counter width for a given operand width
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CNT_W_MIN = 1;

  // $clog2 returns 0 for WIDTH=1, so the result is clamped to one bit.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w);
    if (r < CNT_W_MIN) r = CNT_W_MIN;
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Handshake and operand/result bundle for serial_sub_ctrl.
// Signals:
//   start      - operation request, master -> slave
//   a, b       - minuend / subtrahend, master -> slave
//   busy       - operation in progress, slave -> master
//   done       - one-cycle result-valid pulse, slave -> master
//   difference - (a - b) mod 2^WIDTH, slave -> master
//   borrow     - final borrow-out, slave -> master
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, difference, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, difference, borrow
  );

endinterface

// File: rtl/full_sub_cell.sv
// One-bit full subtractor cell (purely combinational).
// Ports:
//   x    - minuend bit
//   y    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit
//   bout - borrow out
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller: computes a - b one bit per
// clock, LSB first, through a single full_sub_cell with a registered borrow.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - serial_sub_ctrl_if slave modport: start/a/b in,
//           busy/done/difference/borrow out
module serial_sub_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  bus
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             bflop;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             cell_d;
  logic             cell_bout;

  logic             accept;
  logic             last;
  logic             busy_c;
  logic             done_c;

  full_sub_cell u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bflop),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Result register shifts right with the new bit entering at the MSB.
  // Written as shift/OR so it also elaborates for WIDTH=1.
  assign sr_nxt = (sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      bflop    <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      sa    <= bus.a;
      sb    <= bus.b;
      sr    <= '0;
      bflop <= 1'b0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      sr    <= sr_nxt;
      bflop <= cell_bout;
      // Counter parks at the last value; it is reloaded on the next accept.
      if (!last) begin
        cnt <= cnt + 1'b1;
      end
      // Outputs are only ever loaded as a complete word on the final bit.
      if (last) begin
        diff_q   <= sr_nxt;
        borrow_q <= cell_bout;
      end
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.difference = diff_q;
  assign bus.borrow     = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8 main instance, WIDTH=1 side
// instance). Expected results come from plain integer subtraction.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_sub_ctrl_if #(.WIDTH(W)) bus8 ();
  serial_sub_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_sub_ctrl #(.WIDTH(W)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         brw;
    int           edge_n;
  } exp_t;

  exp_t         sbq[$];
  exp_t         popped;

  int           cyc       = 0;
  int           next_free = 0;
  bit           acc_valid = 1'b0;
  int           acc_edge  = 0;
  logic [W-1:0] held_d    = '0;
  logic         held_b    = 1'b0;
  logic [W-1:0] pend_d    = '0;
  logic         pend_b    = 1'b0;
  int           m_a, m_b;
  bit           e_busy, e_done;

  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: acceptance is possible once the previous operation's
  // WIDTH+2 cycle issue interval has elapsed.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        if (acc_valid && cyc == acc_edge + W) begin
          held_d = pend_d;
          held_b = pend_b;
        end
        if (bus8.start === 1'b1 && cyc >= next_free) begin
          m_a    = int'(bus8.a);
          m_b    = int'(bus8.b);
          pend_d = W'(m_a - m_b + 256);
          pend_b = (m_a < m_b);
          sbq.push_back('{pend_d, pend_b, cyc + W});
          acc_valid = 1'b1;
          acc_edge  = cyc;
          next_free = cyc + W + 2;
        end
      end
    end
  end

  // Monitor: compares handshake and held outputs every cycle, pops the
  // scoreboard on each done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        e_busy = acc_valid && (cyc >= acc_edge) && (cyc <= acc_edge + W);
        e_done = acc_valid && (cyc == acc_edge + W);
        chk("busy", bus8.busy, e_busy);
        chk("done", bus8.done, e_done);
        chk("difference_held", bus8.difference, held_d);
        chk("borrow_held", bus8.borrow, held_b);
        if (bus8.done === 1'b1) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            popped = sbq.pop_front();
            chk("sb_difference", bus8.difference, popped.diff);
            chk("sb_borrow", bus8.borrow, popped.brw);
            chk("sb_done_edge", cyc, popped.edge_n);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (cyc + 1 < next_free && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_ready_timeout", 1, 0);
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    wait_ready();
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = W'($urandom);
    bus8.b     = W'($urandom);
  endtask

  task automatic model_reset();
    sbq.delete();
    acc_valid = 1'b0;
    next_free = 0;
    held_d    = '0;
    held_b    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] ii;
    logic       a1, b1;
    int         k, n;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", bus8.busy, 0);
    chk("rst_done", bus8.done, 0);
    chk("rst_difference", bus8.difference, 0);
    chk("rst_borrow", bus8.borrow, 0);
    chk("rst_w1_done", bus1.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases; the second issue also exercises holding of 0x1E.
    issue(8'h5A, 8'h3C);
    issue(8'h00, 8'h01);
    issue(8'hFF, 8'hFF);
    issue(8'h80, 8'h7F);
    issue(8'h00, 8'h00);
    issue(8'hFF, 8'h00);
    wait_ready();

    // Start held high with operands changing every cycle.
    repeat (45) begin
      bus8.start = 1'b1;
      bus8.a     = W'($urandom);
      bus8.b     = W'($urandom);
      @(negedge clk);
    end
    bus8.start = 1'b0;
    wait_ready();

    // Asynchronous reset in the middle of a shift sequence.
    issue(8'h10, 8'h20);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", bus8.busy, 0);
    chk("arst_done", bus8.done, 0);
    chk("arst_difference", bus8.difference, 0);
    chk("arst_borrow", bus8.borrow, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h20, 8'h10);

    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(W'($urandom), W'($urandom));
    end
    wait_ready();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    // WIDTH=1 instance: all four operand combinations.
    for (int i = 0; i < 4; i++) begin
      ii = i[1:0];
      a1 = ii[1];
      b1 = ii[0];
      bus1.start = 1'b1;
      bus1.a     = a1;
      bus1.b     = b1;
      k = cyc + 1;
      @(negedge clk);
      bus1.start = 1'b0;
      chk("w1_busy", bus1.busy, 1);
      n = 0;
      while (bus1.done !== 1'b1 && n < 6) begin
        @(negedge clk);
        n++;
      end
      chk("w1_done_seen", bus1.done, 1);
      chk("w1_latency", cyc, k + 1);
      chk("w1_difference", bus1.difference, (int'(a1) + 2 - int'(b1)) % 2);
      chk("w1_borrow", bus1.borrow, (int'(a1) < int'(b1)) ? 1 : 0);
      @(negedge clk);
      chk("w1_done_pulse", bus1.done, 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
